// File: rtl/spi_ram_master.sv
// -----------------------------------------------------------------------------
// spi_ram_master
//
// SPI command initiator for the SPI-attached 256x8 RAM slave. A host hands over
// one command per valid/ready handshake; the block frames it with ss_n_o low,
// shifts the 10-bit {op, data} word out on mosi_o MSB first (preceded by a
// one-cycle START that already presents the control bit), and for read-data
// commands waits RD_WAIT cycles and then captures an 8-bit reply from miso_i.
// The SPI side runs at one bit per clk.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset (aborts any frame at once)
//   cmd_valid_i  host presents a command
//   cmd_ready_o  block accepts a command (IDLE only)
//   cmd_op_i     00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data
//   cmd_data_i   address or data byte (shifted out as-is, also for op 11)
//   rsp_valid_o  one-cycle pulse when rsp_data_o holds a fresh read byte
//   rsp_data_o   last byte read from the RAM, held between reads
//   busy_o       high from accept until back in IDLE
//   ss_n_o       SPI chip select, active low
//   mosi_o       SPI serial data to the slave
//   miso_i       SPI serial data from the slave
// -----------------------------------------------------------------------------
module spi_ram_master #(
    parameter int unsigned RD_WAIT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [1:0] cmd_op_i,
    input  logic [7:0] cmd_data_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_data_o,
    output logic       busy_o,
    output logic       ss_n_o,
    output logic       mosi_o,
    input  logic       miso_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SHIFT,
        S_WAIT,
        S_CAPTURE,
        S_END
    } state_t;

    // Last value of the wait counter before moving on to CAPTURE.
    localparam logic [3:0] WaitLast = (RD_WAIT > 0) ? 4'(RD_WAIT - 1) : 4'd0;

    state_t     state_q,    state_d;
    logic [9:0] frame_q,    frame_d;
    logic       isRead_q,   isRead_d;
    logic [3:0] bitCnt_q,   bitCnt_d;
    logic [3:0] waitCnt_q,  waitCnt_d;
    logic [7:0] rxShift_q,  rxShift_d;
    logic [7:0] rspData_q,  rspData_d;

    // State and datapath registers. Reset forces IDLE, which drives ss_n_o high
    // combinationally, so an in-flight frame is cut off without waiting for clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            frame_q   <= '0;
            isRead_q  <= 1'b0;
            bitCnt_q  <= '0;
            waitCnt_q <= '0;
            rxShift_q <= '0;
            rspData_q <= '0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            isRead_q  <= isRead_d;
            bitCnt_q  <= bitCnt_d;
            waitCnt_q <= waitCnt_d;
            rxShift_q <= rxShift_d;
            rspData_q <= rspData_d;
        end
    end

    // Next-state and output decode. The frame register is shifted left during
    // SHIFT so mosi_o always presents bit 9; START shows bit 9 without shifting,
    // which is why the control bit appears twice on the wire.
    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        isRead_d    = isRead_q;
        bitCnt_d    = bitCnt_q;
        waitCnt_d   = waitCnt_q;
        rxShift_d   = rxShift_q;
        rspData_d   = rspData_q;
        ss_n_o      = 1'b1;
        mosi_o      = 1'b0;
        cmd_ready_o = 1'b0;
        busy_o      = 1'b1;
        rsp_valid_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (cmd_valid_i) begin
                    frame_d   = {cmd_op_i, cmd_data_i};
                    isRead_d  = (cmd_op_i == 2'b11);
                    bitCnt_d  = '0;
                    waitCnt_d = '0;
                    state_d   = S_START;
                end
            end

            S_START: begin
                ss_n_o  = 1'b0;
                mosi_o  = frame_q[9];
                state_d = S_SHIFT;
            end

            S_SHIFT: begin
                ss_n_o   = 1'b0;
                mosi_o   = frame_q[9];
                frame_d  = {frame_q[8:0], 1'b0};
                bitCnt_d = bitCnt_q + 4'd1;
                if (bitCnt_q == 4'd9) begin
                    bitCnt_d = '0;
                    if (!isRead_q) begin
                        state_d = S_END;
                    end else if (RD_WAIT > 0) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_CAPTURE;
                    end
                end
            end

            S_WAIT: begin
                ss_n_o    = 1'b0;
                waitCnt_d = waitCnt_q + 4'd1;
                if (waitCnt_q == WaitLast) begin
                    waitCnt_d = '0;
                    state_d   = S_CAPTURE;
                end
            end

            // The eighth sample goes straight into the response register so the
            // new byte is already visible during the END cycle with the pulse.
            S_CAPTURE: begin
                ss_n_o    = 1'b0;
                rxShift_d = {rxShift_q[6:0], miso_i};
                bitCnt_d  = bitCnt_q + 4'd1;
                if (bitCnt_q == 4'd7) begin
                    bitCnt_d  = '0;
                    rspData_d = {rxShift_q[6:0], miso_i};
                    state_d   = S_END;
                end
            end

            S_END: begin
                rsp_valid_o = isRead_q;
                state_d     = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rsp_data_o = rspData_q;

endmodule
